// File: rtl/disp_scan_sched_pkg.sv
// Shared definitions for the display scan scheduler: FSM states, slot
// geometry and the hex-to-seven-segment pattern table.
package disp_scan_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHOW  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam int NUM_SLOTS   = 9;
    localparam int STATUS_SLOT = 8;

    localparam logic [7:0] BLANK_BYTE = 8'h00;

    // Entry n is the {a,b,c,d,e,f,g,dp} pattern for hex digit n.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

endpackage

// File: rtl/disp_scan_sched_if.sv
// Debug read port and display outputs of the scan scheduler.
// master: the scheduler side; slave: the core / display side.
interface disp_scan_sched_if;

    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic [7:0]  ctl;
    logic        freeze;
    logic [63:0] disp;
    logic [8:0]  sl_out;
    logic        stale;

    modport master (
        output rd_req, rd_addr, disp, sl_out, stale,
        input  rd_gnt, rd_data, ctl, freeze
    );

    modport slave (
        input  rd_req, rd_addr, disp, sl_out, stale,
        output rd_gnt, rd_data, ctl, freeze
    );

endinterface

// File: rtl/disp_scan_sched_seg7_hex_enc.sv
// One hex nibble to one seven-segment byte, purely combinational.
module seg7_hex_enc
    import disp_scan_sched_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/disp_scan_sched.sv
// Scan scheduler for the 8-digit / 9-select debug display. Walks the 16
// general registers in pairs (slots 0..7) through the shared debug read
// port, keeps each pair in a shadow buffer, then shows the status byte in
// slot 8. Every slot is followed by an all-select-low guard interval.
//
// Build option: define DISP_SCAN_LZB_EN to blank leading zero digits of
// each 16-bit register (the least significant digit is always shown).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | one cycle after reset, then start at slot 0
// ST_FETCH | request pair s (slots 0..7) or pass straight through (8)
// ST_SHOW  | select line for slot s asserted for ON_TICKS ticks
// ST_GUARD | all selects low for GUARD_TICKS ticks, then next slot
module disp_scan_sched
    import disp_scan_sched_pkg::*;
#(
    parameter int TICK_DIV    = 66666,
    parameter int ON_TICKS    = 2,
    parameter int GUARD_TICKS = 2,
    parameter int FETCH_TO    = 255
) (
    input  logic              clk,
    input  logic              rst,
    disp_scan_sched_if.master bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t           state_q, state_d;
    logic [3:0]       slot_q, slot_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic             rd_req_q, rd_req_d;
    logic [2:0]       rd_addr_q, rd_addr_d;
    logic [63:0]      disp_q, disp_d;
    logic [8:0]       sl_out_q, sl_out_d;
    logic             stale_q, stale_d;
    logic [7:0][31:0] shadow_q, shadow_d;

    logic             tick;
    logic             is_status;
    logic             use_bus;
    logic [31:0]      src_data;
    logic [7:0][7:0]  enc_bytes;
    logic [7:0][7:0]  show_bytes;
    logic             enter_fetch;
    logic             enter_show;
    logic [3:0]       next_slot;

    assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign is_status = (slot_q == 4'(STATUS_SLOT));
    assign use_bus   = (state_q == ST_FETCH) && rd_req_q && bus.rd_gnt;
    assign src_data  = use_bus ? bus.rd_data : shadow_q[slot_q[2:0]];

    // Bytes 0..3 carry reg[2k] most significant nibble first, 4..7 reg[2k+1].
    for (genvar gi = 0; gi < 8; gi++) begin : g_enc
        localparam int NB = (gi < 4) ? (3 - gi) : (11 - gi);
        seg7_hex_enc u_enc (
            .nib (src_data[4*NB +: 4]),
            .seg (enc_bytes[gi])
        );
    end

`ifdef DISP_SCAN_LZB_EN
    // Blank leading zero digits per register; the lowest digit always shows.
    always_comb begin
        show_bytes = enc_bytes;
        for (int h = 0; h < 2; h++) begin
            if (src_data[16*h+12 +: 4] == 4'h0)    show_bytes[4*h]   = BLANK_BYTE;
            if (src_data[16*h+8 +: 8] == 8'h00)    show_bytes[4*h+1] = BLANK_BYTE;
            if (src_data[16*h+4 +: 12] == 12'h000) show_bytes[4*h+2] = BLANK_BYTE;
        end
    end
`else
    assign show_bytes = enc_bytes;
`endif

    // Free-running scan tick divider.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // Slot sequencing, fetch handshake and display register updates.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        tcnt_d      = tcnt_q;
        fcnt_d      = fcnt_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        disp_d      = disp_q;
        sl_out_d    = sl_out_q;
        stale_d     = stale_q;
        shadow_d    = shadow_q;
        enter_fetch = 1'b0;
        enter_show  = 1'b0;
        next_slot   = slot_q;

        case (state_q)
            ST_IDLE: begin
                enter_fetch = 1'b1;
                next_slot   = 4'd0;
            end
            ST_FETCH: begin
                // No request outstanding means status slot or frozen entry.
                if (is_status || !rd_req_q) begin
                    stale_d    = 1'b0;
                    enter_show = 1'b1;
                end else if (bus.rd_gnt) begin
                    shadow_d[slot_q[2:0]] = bus.rd_data;
                    rd_req_d   = 1'b0;
                    stale_d    = 1'b0;
                    enter_show = 1'b1;
                end else if (fcnt_q == '0) begin
                    rd_req_d   = 1'b0;
                    stale_d    = 1'b1;
                    enter_show = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - 16'd1;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    if (tcnt_q == '0) begin
                        state_d  = ST_GUARD;
                        tcnt_d   = 16'(GUARD_TICKS - 1);
                        sl_out_d = '0;
                    end else begin
                        tcnt_d = tcnt_q - 16'd1;
                    end
                end
            end
            ST_GUARD: begin
                if (tick) begin
                    if (tcnt_q == '0) begin
                        enter_fetch = 1'b1;
                        next_slot   = (slot_q == 4'(NUM_SLOTS - 1)) ? 4'd0 : slot_q + 4'd1;
                    end else begin
                        tcnt_d = tcnt_q - 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_show) begin
            state_d = ST_SHOW;
            tcnt_d  = 16'(ON_TICKS - 1);
            if (is_status) begin
                disp_d   = {{7{BLANK_BYTE}}, bus.ctl};
                sl_out_d = 9'h100;
            end else begin
                disp_d   = show_bytes;
                sl_out_d = 9'h080 >> slot_q;
            end
        end

        // freeze is only looked at here, so mid-slot changes wait for the next entry.
        if (enter_fetch) begin
            state_d = ST_FETCH;
            slot_d  = next_slot;
            fcnt_d  = 16'(FETCH_TO - 1);
            if (next_slot != 4'(STATUS_SLOT)) begin
                rd_addr_d = next_slot[2:0];
                rd_req_d  = ~bus.freeze;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            tick_cnt_q <= '0;
            tcnt_q     <= '0;
            fcnt_q     <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            disp_q     <= '0;
            sl_out_q   <= '0;
            stale_q    <= 1'b0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            tick_cnt_q <= tick_cnt_d;
            tcnt_q     <= tcnt_d;
            fcnt_q     <= fcnt_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            disp_q     <= disp_d;
            sl_out_q   <= sl_out_d;
            stale_q    <= stale_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus.rd_req  = rd_req_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.disp    = disp_q;
    assign bus.sl_out  = sl_out_q;
    assign bus.stale   = stale_q;

endmodule

// File: tb/tb_disp_scan_sched.sv
// Scoreboard bench for disp_scan_sched: the stimulus process queues the
// expected slot displays and read addresses, a monitor pops and compares
// them whenever a select line rises or a request is raised.
module tb_disp_scan_sched;

    localparam int TICK_DIV    = 4;
    localparam int ON_TICKS    = 2;
    localparam int GUARD_TICKS = 2;
    localparam int FETCH_TO    = 255;
    localparam int MIN_GAP     = GUARD_TICKS * TICK_DIV;

`ifdef DISP_SCAN_LZB_EN
    localparam logic [63:0] LIT_A0 = 64'h3EEEF6FE_F2DA6000;
    localparam logic [63:0] LIT_C0 = 64'hFC000000_E0000000;
`else
    localparam logic [63:0] LIT_A0 = 64'h3EEEF6FE_F2DA60FC;
    localparam logic [63:0] LIT_C0 = 64'hFCFCFCFC_E0FCFCFC;
`endif

    typedef struct packed {
        logic [3:0]  slot;
        logic [8:0]  sl;
        logic [63:0] disp;
        logic        stale;
    } exp_t;

    logic clk;
    logic rst;

    disp_scan_sched_if dut_if ();

    disp_scan_sched #(
        .TICK_DIV    (TICK_DIV),
        .ON_TICKS    (ON_TICKS),
        .GUARD_TICKS (GUARD_TICKS),
        .FETCH_TO    (FETCH_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.master)
    );

    int n_tests     = 0;
    int n_fail      = 0;
    int n_slot_ev   = 0;
    int n_req_rises = 0;

    exp_t        exp_q[$];
    logic [2:0]  addr_q[$];
    logic [31:0] mem_a[8];
    logic [31:0] mem_b[8];
    logic [31:0] mem_c[8];
    int          cur_tid = 0;
    int          gnt_dly = 3;
    bit          chk_to  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;  4'h1: return 8'h60;  4'h2: return 8'hDA;  4'h3: return 8'hF2;
            4'h4: return 8'h66;  4'h5: return 8'hB6;  4'h6: return 8'hBE;  4'h7: return 8'hE0;
            4'h8: return 8'hFE;  4'h9: return 8'hF6;  4'hA: return 8'hEE;  4'hB: return 8'h3E;
            4'hC: return 8'h1A;  4'hD: return 8'h7A;  4'hE: return 8'h9E;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [31:0] half_bytes(input logic [15:0] r);
        logic [31:0] b;
        b[7:0]   = seg_of(r[15:12]);
        b[15:8]  = seg_of(r[11:8]);
        b[23:16] = seg_of(r[7:4]);
        b[31:24] = seg_of(r[3:0]);
`ifdef DISP_SCAN_LZB_EN
        if (r[15:12] == 4'h0) b[7:0]   = 8'h00;
        if (r[15:8] == 8'h00) b[15:8]  = 8'h00;
        if (r[15:4] == 12'h0) b[23:16] = 8'h00;
`endif
        return b;
    endfunction

    function automatic logic [63:0] exp_disp(input logic [31:0] w);
        return {half_bytes(w[31:16]), half_bytes(w[15:0])};
    endfunction

    function automatic logic [31:0] word_of(input int tid, input int k);
        if (tid == 0) return mem_a[k];
        if (tid == 1) return mem_b[k];
        return mem_c[k];
    endfunction

    task automatic push_pass(input int tid, input bit stl, input logic [7:0] c, input bit with_addr);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.slot  = 4'(k);
            e.sl    = 9'h080 >> k;
            e.disp  = exp_disp(word_of(tid, k));
            e.stale = stl;
            if (k == 0 && tid == 0) e.disp = LIT_A0;
            if (k == 0 && tid == 2) e.disp = LIT_C0;
            exp_q.push_back(e);
            if (with_addr) addr_q.push_back(3'(k));
        end
        e.slot  = 4'd8;
        e.sl    = 9'h100;
        e.disp  = {56'h0, c};
        e.stale = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_slots(input int target, input string nm);
        int cyc;
        cyc = 0;
        while (n_slot_ev < target && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(nm, 64'(n_slot_ev >= target), 64'd1);
    endtask

    // Grant responder: grants gnt_dly cycles after a request, never if negative.
    initial begin : responder
        int cnt;
        int hi;
        cnt = 0;
        hi  = 0;
        dut_if.rd_gnt  = 1'b0;
        dut_if.rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dut_if.rd_gnt) begin
                dut_if.rd_gnt = 1'b0;
                chk("rd_req_drop_after_gnt", 64'(dut_if.rd_req), 64'd0);
                cnt = 0;
                hi  = 0;
            end else if (dut_if.rd_req === 1'b1) begin
                hi++;
                if (gnt_dly >= 0 && cnt == gnt_dly) begin
                    dut_if.rd_gnt  = 1'b1;
                    dut_if.rd_data = word_of(cur_tid, int'(dut_if.rd_addr));
                end else begin
                    cnt++;
                end
            end else begin
                if (hi != 0 && chk_to) chk("timeout_req_len", 64'(hi), 64'(FETCH_TO));
                hi  = 0;
                cnt = 0;
            end
        end
    end

    // Monitor: compares each new slot display and each new request address.
    initial begin : monitor
        logic [8:0] prev_sl;
        logic       prev_req;
        int         gap;
        bit         seen;
        exp_t       e;
        prev_sl  = '0;
        prev_req = 1'b0;
        gap      = 0;
        seen     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dut_if.rd_req === 1'b1 && !prev_req) begin
                n_req_rises++;
                chk("rd_req_expected", 64'(addr_q.size() > 0), 64'd1);
                if (addr_q.size() > 0) chk("rd_addr", 64'(dut_if.rd_addr), 64'(addr_q.pop_front()));
            end
            if (dut_if.sl_out !== 9'h000 && !$isunknown(dut_if.sl_out) && prev_sl == 9'h000) begin
                n_slot_ev++;
                chk("sl_onehot", 64'($onehot(dut_if.sl_out)), 64'd1);
                if (seen) chk("guard_gap_ok", 64'(gap >= MIN_GAP), 64'd1);
                seen = 1'b1;
                gap  = 0;
                chk("slot_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("s%0d_sl_out", e.slot), 64'(dut_if.sl_out), 64'(e.sl));
                    chk($sformatf("s%0d_disp", e.slot), dut_if.disp, e.disp);
                    chk($sformatf("s%0d_stale", e.slot), 64'(dut_if.stale), 64'(e.stale));
                end
            end
            if (dut_if.sl_out === 9'h000) gap++;
            prev_sl  = (dut_if.sl_out === 9'h000 || $isunknown(dut_if.sl_out)) ? 9'h000 : dut_if.sl_out;
            prev_req = (dut_if.rd_req === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=time_limit required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int cyc;
        mem_a[0] = 32'h89AB_0123;  mem_a[1] = 32'h4567_CDEF;
        mem_a[2] = 32'h0000_FFFF;  mem_a[3] = 32'h00F0_0A0B;
        mem_a[4] = 32'h1000_0001;  mem_a[5] = 32'hDEAD_BEEF;
        mem_a[6] = 32'h0F00_00C0;  mem_a[7] = 32'h7654_3210;
        for (int k = 0; k < 8; k++) begin
            mem_b[k] = {16'hA5A0 + 16'(k), 16'h0050 + 16'(k)};
            mem_c[k] = {16'h00E0 | 16'(k), 16'h3000 | 16'(k)};
        end
        mem_c[0] = 32'h0000_0007;

        rst           = 1'b1;
        dut_if.ctl    = 8'hC3;
        dut_if.freeze = 1'b0;
        cur_tid       = 0;
        gnt_dly       = 3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_req", 64'(dut_if.rd_req), 64'd0);
        chk("reset_rd_addr", 64'(dut_if.rd_addr), 64'd0);
        chk("reset_disp", dut_if.disp, 64'd0);
        chk("reset_sl_out", 64'(dut_if.sl_out), 64'd0);
        chk("reset_stale", 64'(dut_if.stale), 64'd0);

        // pass A: grant three cycles after each request
        push_pass(0, 1'b0, 8'hC3, 1'b1);
        rst = 1'b0;
        wait_slots(9, "pass_a_done");

        // pass B: immediate grants, new register contents
        cur_tid    = 1;
        gnt_dly    = 0;
        dut_if.ctl = 8'h81;
        push_pass(1, 1'b0, 8'h81, 1'b1);
        wait_slots(18, "pass_b_done");

        // pass C: no grants, shadow from pass B shown as stale
        gnt_dly    = -1;
        chk_to     = 1'b1;
        dut_if.ctl = 8'h24;
        push_pass(1, 1'b1, 8'h24, 1'b1);
        wait_slots(27, "pass_timeout_done");

        // pass D: frozen, shadow replayed without requests
        chk_to        = 1'b0;
        dut_if.freeze = 1'b1;
        dut_if.ctl    = 8'h5A;
        base          = n_req_rises;
        push_pass(1, 1'b0, 8'h5A, 1'b0);
        wait_slots(36, "pass_freeze_done");
        chk("freeze_req_count", 64'(n_req_rises - base), 64'd0);

        // reset while a request is outstanding and never granted
        dut_if.freeze = 1'b0;
        addr_q.push_back(3'd0);
        base = n_req_rises;
        cyc  = 0;
        while (n_req_rises == base && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("req_before_reset", 64'(n_req_rises > base), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("req_held_no_gnt", 64'(dut_if.rd_req), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midfetch_rst_rd_req", 64'(dut_if.rd_req), 64'd0);
        chk("midfetch_rst_disp", dut_if.disp, 64'd0);
        chk("midfetch_rst_sl_out", 64'(dut_if.sl_out), 64'd0);
        chk("midfetch_rst_stale", 64'(dut_if.stale), 64'd0);

        // pass E: restart from slot 0 with one-cycle grants
        cur_tid    = 2;
        gnt_dly    = 1;
        dut_if.ctl = 8'h3C;
        base       = n_req_rises;
        push_pass(2, 1'b0, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_slots(45, "pass_restart_done");
        chk("restart_req_count", 64'(n_req_rises - base), 64'd8);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
